seq_count_ctrl: RTL and testbench

//   Parametrised start/count/terminate controller: on start (s), counts qualified

---
 rtl/seq_count_pkg.sv | 15 +
 rtl/up_counter_en.sv | 27 ++
 rtl/seq_count_ctrl.sv | 129 ++++++++++++
 tb/tb_seq_count_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_count_pkg.sv
// Shared definitions for the seq_count_ctrl start/count/terminate controller:
// FSM state encoding and default parameter values.
package seq_count_pkg;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_TIMEOUT = 8;

    // 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/up_counter_en.sv
// WIDTH-generic up counter with synchronous clear and count enable.
// Clear has priority over enable; the count wraps modulo 2^WIDTH.
module up_counter_en
    import seq_count_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // NOTE: clr is tested first so a clear always wins over a count request.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= r_q + WIDTH'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/seq_count_ctrl.sv
// Start/count/terminate controller: counts qualified x cycles up to a latched
// terminal value, then pulses g. Optional ARM-state abort via SEQ_COUNT_TIMEOUT_EN.
module seq_count_ctrl
    import seq_count_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic             x,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] q,
    output logic             z,
    output logic             g,
    output logic             busy,
    output logic             err
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_term;
    logic [WIDTH-1:0] w_q;
    logic             r_g;
    logic             w_g_next;
    logic             w_start;
    logic             w_en;
    logic             w_clr;
    logic             w_timeout;

    // Reset clears the count through the same path as a start.
    assign w_clr = reset | w_start;

    up_counter_en #(
        .WIDTH (WIDTH)
    ) u_count (
        .clk (clk),
        .clr (w_clr),
        .en  (w_en),
        .q   (w_q)
    );

    assign q    = w_q;
    assign z    = (w_q == r_term);
    assign g    = r_g;
    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_term  <= '0;
            r_g     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_g     <= w_g_next;
            if (w_start) begin
                r_term <= term;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no latches.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_en         = 1'b0;
        w_g_next     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s) begin
                    w_state_next = ST_ARM;
                    w_start      = 1'b1;
                end
            end
            ST_ARM: begin
                if (x) begin
                    w_en         = 1'b1;
                    w_state_next = ST_RUN;
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (z) begin
                    w_state_next = ST_IDLE;
                    w_g_next     = 1'b1;
                end else if (x) begin
                    w_en = 1'b1;
                end else begin
                    w_state_next = ST_ARM;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

`ifdef SEQ_COUNT_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_err;

    // Limit is hit on the TIMEOUT-th consecutive x-low ARM cycle; x=1 still wins.
    assign w_timeout = (r_state == ST_ARM) && (r_idle_cnt == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_timeout & ~x;
            if ((r_state == ST_ARM) && !x && !w_timeout) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_seq_count_ctrl.sv
// Scoreboard bench for seq_count_ctrl (WIDTH=4, TIMEOUT=8); the timeout scenario
// follows SEQ_COUNT_TIMEOUT_EN when that macro is defined for the build.
module tb_seq_count_ctrl;

    typedef struct packed {
        logic [3:0] q;
        logic       z;
        logic       g;
        logic       busy;
        logic       err;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic       s;
        logic       x;
        logic [3:0] term;
        obs_t       exp;
    } step_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s = 1'b0;
    logic       x = 1'b0;
    logic [3:0] term = 4'd0;
    logic [3:0] q;
    logic       z;
    logic       g;
    logic       busy;
    logic       err;

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t sb[$];

    always #5 clk = ~clk;

    seq_count_ctrl #(
        .WIDTH   (4),
        .TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .s     (s),
        .x     (x),
        .term  (term),
        .q     (q),
        .z     (z),
        .g     (g),
        .busy  (busy),
        .err   (err)
    );

    function automatic step_t stp(bit r, bit ss, bit xx, int t,
                                  int eq, bit ez, bit eg, bit eb, bit ee);
        step_t o;
        o.rst      = r;
        o.s        = ss;
        o.x        = xx;
        o.term     = 4'(t);
        o.exp.q    = 4'(eq);
        o.exp.z    = ez;
        o.exp.g    = eg;
        o.exp.busy = eb;
        o.exp.err  = ee;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.q    = q;
        o.z    = z;
        o.g    = g;
        o.busy = busy;
        o.err  = err;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("q=%0d z=%b g=%b busy=%b err=%b", o.q, o.z, o.g, o.busy, o.err);
    endfunction

    // Inputs change 1 time unit after the active edge; outputs sampled there too.
    task automatic tick(input step_t t);
        reset = t.rst;
        s     = t.s;
        x     = t.x;
        term  = t.term;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t st[$];
        obs_t  e, got;
        st.push_back(stp(1, 0, 0, 0, 0, 1, 0, 0, 0));
        st.push_back(stp(1, 1, 1, 7, 0, 1, 0, 0, 0));
        st.push_back(stp(0, 0, 1, 7, 0, 1, 0, 0, 0));
        foreach (st[i]) begin
            sb.push_back(st[i].exp);
            tick(st[i]);
            got = observe();
            e   = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_basic();
        step_t st[$];
        obs_t  e, got;
        st.push_back(stp(0, 1, 1, 5, 0, 0, 0, 1, 0));
        for (int k = 1; k <= 5; k++) st.push_back(stp(0, 0, 1, 5, k, k == 5, 0, 1, 0));
        st.push_back(stp(0, 0, 1, 5, 5, 1, 1, 0, 0));
        st.push_back(stp(0, 0, 0, 5, 5, 1, 0, 0, 0));
        foreach (st[i]) begin
            sb.push_back(st[i].exp);
            tick(st[i]);
            got = observe();
            e   = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL basic[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_x_pattern();
        step_t st[$];
        obs_t  e, got;
        bit    xp [11] = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0};
        int    qp [11] = '{1, 2, 2, 2, 3, 4, 4, 5, 6, 6, 6};
        bit    gp [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        st.push_back(stp(0, 1, 0, 6, 0, 0, 0, 1, 0));
        for (int k = 0; k < 11; k++)
            st.push_back(stp(0, 0, xp[k], 6, qp[k], qp[k] == 6, gp[k], k < 9, 0));
        foreach (st[i]) begin
            sb.push_back(st[i].exp);
            tick(st[i]);
            got = observe();
            e   = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL x_pattern[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_wrap();
        step_t st[$];
        obs_t  e, got;
        st.push_back(stp(0, 1, 1, 0, 0, 1, 0, 1, 0));
        for (int k = 1; k <= 15; k++) st.push_back(stp(0, 0, 1, 0, k, 0, 0, 1, 0));
        st.push_back(stp(0, 0, 1, 0, 0, 1, 0, 1, 0));
        st.push_back(stp(0, 0, 1, 0, 0, 1, 1, 0, 0));
        st.push_back(stp(0, 0, 0, 0, 0, 1, 0, 0, 0));
        foreach (st[i]) begin
            sb.push_back(st[i].exp);
            tick(st[i]);
            got = observe();
            e   = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL wrap[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_term_change();
        step_t st[$];
        obs_t  e, got;
        st.push_back(stp(0, 1, 1, 5, 0, 0, 0, 1, 0));
        for (int k = 1; k <= 5; k++) st.push_back(stp(0, k == 3, 1, 2, k, k == 5, 0, 1, 0));
        st.push_back(stp(0, 0, 1, 2, 5, 1, 1, 0, 0));
        st.push_back(stp(0, 0, 0, 2, 5, 1, 0, 0, 0));
        foreach (st[i]) begin
            sb.push_back(st[i].exp);
            tick(st[i]);
            got = observe();
            e   = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL term_change[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t st[$];
        obs_t  e, got;
        st.push_back(stp(0, 1, 1, 9, 0, 0, 0, 1, 0));
        for (int k = 1; k <= 3; k++) st.push_back(stp(0, 0, 1, 9, k, 0, 0, 1, 0));
        st.push_back(stp(1, 1, 1, 9, 0, 1, 0, 0, 0));
        st.push_back(stp(0, 0, 1, 9, 0, 1, 0, 0, 0));
        foreach (st[i]) begin
            sb.push_back(st[i].exp);
            tick(st[i]);
            got = observe();
            e   = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_mid[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_timeout();
        step_t st[$];
        obs_t  e, got;
`ifdef SEQ_COUNT_TIMEOUT_EN
        st.push_back(stp(0, 1, 0, 2, 0, 0, 0, 1, 0));
        st.push_back(stp(0, 0, 1, 2, 1, 0, 0, 1, 0));
        st.push_back(stp(0, 0, 0, 2, 1, 0, 0, 1, 0));
        for (int k = 1; k <= 7; k++) st.push_back(stp(0, 0, 0, 2, 1, 0, 0, 1, 0));
        st.push_back(stp(0, 0, 0, 2, 1, 0, 0, 0, 1));
        st.push_back(stp(0, 0, 0, 2, 1, 0, 0, 0, 0));
        st.push_back(stp(0, 1, 0, 2, 0, 0, 0, 1, 0));
        for (int k = 1; k <= 7; k++) st.push_back(stp(0, 0, 0, 2, 0, 0, 0, 1, 0));
        st.push_back(stp(0, 0, 1, 2, 1, 0, 0, 1, 0));
`else
        st.push_back(stp(0, 1, 0, 2, 0, 0, 0, 1, 0));
        for (int k = 1; k <= 12; k++) st.push_back(stp(0, 0, 0, 2, 0, 0, 0, 1, 0));
        st.push_back(stp(0, 0, 1, 2, 1, 0, 0, 1, 0));
`endif
        st.push_back(stp(0, 0, 1, 2, 2, 1, 0, 1, 0));
        st.push_back(stp(0, 0, 0, 2, 2, 1, 1, 0, 0));
        st.push_back(stp(0, 0, 0, 2, 2, 1, 0, 0, 0));
        foreach (st[i]) begin
            sb.push_back(st[i].exp);
            tick(st[i]);
            got = observe();
            e   = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL timeout[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_x_pattern();
        test_wrap();
        test_term_change();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
